axi_rd_arbiter: RTL and testbench
=================================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: AXI read address width.
REQ-002 SHALL have parameter DW, default 64: AXI read data width.
REQ-003 SHALL have port CLK, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port RSTn, input, 1: synchronous, active-low reset.
REQ-005 SHALL have master ports IL1_ARADDR/ARLEN/ARBURST/ARVALID, inputs, AW/8/2/1, and IL1_ARREADY, output, 1: instruction-cache read-address channel.
REQ-006 SHALL have IL1_RDATA/RRESP/RLAST/RVALID, outputs, DW/2/1/1, and IL1_RREADY, input, 1: instruction-cache read-data channel.
REQ-007 SHALL have DL1_* ports identical to REQ-005/006: data-cache read channels.
REQ-008 SHALL have MEM_ARADDR/ARLEN/ARBURST/ARVALID, outputs, AW/8/2/1, and MEM_ARREADY, input, 1: shared downstream read-address channel.
REQ-009 SHALL have MEM_RDATA/RRESP/RLAST/RVALID, inputs, DW/2/1/1, and MEM_RREADY, output, 1: shared downstream read-data channel.
REQ-010 SHALL have rd_protocol_err, output, 1: sticky flag for RLAST/ARLEN beat mismatch.

Function
REQ-011 SHALL implement FSM states IDLE, ADDR, DATA; one outstanding transaction at a time.
REQ-012 IDLE: if any master's ARVALID=1, SHALL grant one, assert that master's ARREADY combinationally in the same cycle, and latch ARADDR/ARLEN/ARBURST and grant id; next state ADDR.
REQ-013 Arbitration SHALL be round-robin: with both requesting, grant the master not granted last; after reset, IL1 wins first.
REQ-014 Non-granted master's ARREADY SHALL be 0 in every state; ARREADY SHALL be 0 in ADDR and DATA.
REQ-015 ADDR: MEM_ARVALID SHALL be 1, MEM_AR* driven from latched registers and stable until MEM_ARREADY=1; then state DATA and beat counter loaded with latched ARLEN.
REQ-016 DATA: MEM_RDATA/RRESP/RLAST SHALL be broadcast to both masters; RVALID forwarded only to the granted master, 0 to the other.
REQ-017 DATA: MEM_RREADY SHALL equal granted master's RREADY; MEM_RREADY SHALL be 0 outside DATA.
REQ-018 On each R handshake (MEM_RVALID & MEM_RREADY), beat counter SHALL decrement by 1 (8-bit, no wrap below 0).
REQ-019 Handshake with RLAST=1 SHALL return FSM to IDLE next cycle; new grant is possible in that IDLE cycle (min 3-cycle turnaround per burst + beats).
REQ-020 rd_protocol_err SHALL set if RLAST=1 with counter≠0, or a handshake with RLAST=0 occurs when counter=0; it never clears except by reset; FSM still exits on RLAST.
REQ-021 Arbiter SHALL NOT abort a burst; masters discarding data after a pipeline flush SHALL still hold RREADY to drain.
REQ-022 Master ARVALID dropping in ADDR/DATA SHALL have no effect on the latched transaction.

Reset
REQ-023 With RSTn=0 at a rising edge: state IDLE, round-robin pointer to "DL1 last", counter 0, rd_protocol_err 0, latched AR fields 0.
REQ-024 During and after reset: all ARREADY, RVALID, MEM_ARVALID, MEM_RREADY SHALL be 0 until a new grant.
REQ-025 Reset mid-burst SHALL abandon the transaction; the remaining downstream beats are the system's responsibility, since reset is global.

Structure
REQ-026 AXI burst-type encodings and default AW/DW SHALL live in define.vh; FSM state encodings SHALL be local parameters.
REQ-027 SHALL be a single module with no sub-modules; the round-robin pick is inline logic.

Verification
REQ-028 Single IL1 request ARADDR=0x8000_0000, ARLEN=3 -> IL1_ARREADY in the same cycle, MEM_ARVALID the next cycle with identical fields, 4 beats to IL1 only, IDLE after the RLAST beat.
REQ-029 IL1 and DL1 request in the same cycle, both repeating -> grants IL1, DL1, IL1, DL1; DL1_RVALID stays 0 during IL1 bursts.
REQ-030 MEM_ARREADY held low for 5 cycles -> MEM_AR* stable for all 5 cycles, no R forwarding until accepted.
REQ-031 IL1_RREADY toggles 1,0,1,0 during an ARLEN=1 burst -> MEM_RREADY mirrors it, exactly 2 beats transferred, no beat lost.
REQ-032 ARLEN=3 but RLAST on beat 2 -> rd_protocol_err=1 sticky, FSM returns to IDLE, next DL1 request granted normally.
REQ-033 RSTn=0 mid-DATA -> next cycle IDLE, all valids/readies 0, rd_protocol_err 0, next simultaneous request granted to IL1.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// axi_rd_arbiter_pkg: AXI burst encodings, default widths and FSM states for the read arbiter
package axi_rd_arbiter_pkg;
    localparam int AXI_AW = 32;
    localparam int AXI_DW = 64;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
endpackage

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin arbiter of IL1/DL1 AXI read channels onto one memory port, one burst in flight
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int AW = AXI_AW,
    parameter int DW = AXI_DW
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [AW-1:0] IL1_ARADDR,
    input  logic [7:0]    IL1_ARLEN,
    input  logic [1:0]    IL1_ARBURST,
    input  logic          IL1_ARVALID,
    output logic          IL1_ARREADY,
    output logic [DW-1:0] IL1_RDATA,
    output logic [1:0]    IL1_RRESP,
    output logic          IL1_RLAST,
    output logic          IL1_RVALID,
    input  logic          IL1_RREADY,
    input  logic [AW-1:0] DL1_ARADDR,
    input  logic [7:0]    DL1_ARLEN,
    input  logic [1:0]    DL1_ARBURST,
    input  logic          DL1_ARVALID,
    output logic          DL1_ARREADY,
    output logic [DW-1:0] DL1_RDATA,
    output logic [1:0]    DL1_RRESP,
    output logic          DL1_RLAST,
    output logic          DL1_RVALID,
    input  logic          DL1_RREADY,
    output logic [AW-1:0] MEM_ARADDR,
    output logic [7:0]    MEM_ARLEN,
    output logic [1:0]    MEM_ARBURST,
    output logic          MEM_ARVALID,
    input  logic          MEM_ARREADY,
    input  logic [DW-1:0] MEM_RDATA,
    input  logic [1:0]    MEM_RRESP,
    input  logic          MEM_RLAST,
    input  logic          MEM_RVALID,
    output logic          MEM_RREADY,
    output logic          rd_protocol_err
);
    state_t        state, state_nx;
    logic          gnt;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [1:0]    burst;
    logic [7:0]    cnt;
    logic          req_any, pick_dl1, hs;

    // gnt doubles as the round-robin pointer: it holds the last master granted
    always_comb begin
        req_any  = IL1_ARVALID | DL1_ARVALID;
        pick_dl1 = DL1_ARVALID & (!IL1_ARVALID | !gnt);
        hs       = MEM_RVALID & MEM_RREADY;
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = req_any ? ST_ADDR : ST_IDLE;
            ST_ADDR: state_nx = MEM_ARREADY ? ST_DATA : ST_ADDR;
            ST_DATA: state_nx = (hs && MEM_RLAST) ? ST_IDLE : ST_DATA;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign IL1_ARREADY = RSTn && state == ST_IDLE && IL1_ARVALID && !pick_dl1;
    assign DL1_ARREADY = RSTn && state == ST_IDLE && pick_dl1;
    assign MEM_ARVALID = state == ST_ADDR;
    assign MEM_ARADDR  = addr;
    assign MEM_ARLEN   = len;
    assign MEM_ARBURST = burst;
    assign MEM_RREADY  = state == ST_DATA && (gnt ? DL1_RREADY : IL1_RREADY);
    assign IL1_RVALID  = state == ST_DATA && !gnt && MEM_RVALID;
    assign DL1_RVALID  = state == ST_DATA && gnt && MEM_RVALID;
    assign IL1_RDATA   = MEM_RDATA;
    assign IL1_RRESP   = MEM_RRESP;
    assign IL1_RLAST   = MEM_RLAST;
    assign DL1_RDATA   = MEM_RDATA;
    assign DL1_RRESP   = MEM_RRESP;
    assign DL1_RLAST   = MEM_RLAST;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state           <= ST_IDLE;
            gnt             <= 1'b1;
            addr            <= '0;
            len             <= '0;
            burst           <= '0;
            cnt             <= '0;
            rd_protocol_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && req_any) begin
                gnt   <= pick_dl1;
                addr  <= pick_dl1 ? DL1_ARADDR : IL1_ARADDR;
                len   <= pick_dl1 ? DL1_ARLEN : IL1_ARLEN;
                burst <= pick_dl1 ? DL1_ARBURST : IL1_ARBURST;
            end
            if (state == ST_ADDR && MEM_ARREADY)
                cnt <= len;
            // the final beat must coincide with the counter reaching zero
            if (state == ST_DATA && hs) begin
                cnt <= (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
                if (MEM_RLAST != (cnt == 8'd0))
                    rd_protocol_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed and randomized checks of the IL1/DL1 read arbiter against a round-robin burst model
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;
    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rstn;
    logic [1:0][AW-1:0] araddr;
    logic [1:0][7:0]    arlen;
    logic [1:0][1:0]    arburst;
    logic [1:0]         arvalid, arready, rvalid, rready, rlast;
    logic [1:0][DW-1:0] rdata;
    logic [1:0][1:0]    rresp;
    logic [AW-1:0]      mem_araddr;
    logic [7:0]         mem_arlen;
    logic [1:0]         mem_arburst;
    logic               mem_arvalid, mem_arready;
    logic [DW-1:0]      mem_rdata;
    logic [1:0]         mem_rresp;
    logic               mem_rlast, mem_rvalid, mem_rready, err;

    int n_chk = 0;
    int n_fail = 0;
    int last_g = 1;

    always #5 clk = ~clk;

    axi_rd_arbiter dut (
        .CLK(clk), .RSTn(rstn),
        .IL1_ARADDR(araddr[0]), .IL1_ARLEN(arlen[0]), .IL1_ARBURST(arburst[0]),
        .IL1_ARVALID(arvalid[0]), .IL1_ARREADY(arready[0]),
        .IL1_RDATA(rdata[0]), .IL1_RRESP(rresp[0]), .IL1_RLAST(rlast[0]),
        .IL1_RVALID(rvalid[0]), .IL1_RREADY(rready[0]),
        .DL1_ARADDR(araddr[1]), .DL1_ARLEN(arlen[1]), .DL1_ARBURST(arburst[1]),
        .DL1_ARVALID(arvalid[1]), .DL1_ARREADY(arready[1]),
        .DL1_RDATA(rdata[1]), .DL1_RRESP(rresp[1]), .DL1_RLAST(rlast[1]),
        .DL1_RVALID(rvalid[1]), .DL1_RREADY(rready[1]),
        .MEM_ARADDR(mem_araddr), .MEM_ARLEN(mem_arlen), .MEM_ARBURST(mem_arburst),
        .MEM_ARVALID(mem_arvalid), .MEM_ARREADY(mem_arready),
        .MEM_RDATA(mem_rdata), .MEM_RRESP(mem_rresp), .MEM_RLAST(mem_rlast),
        .MEM_RVALID(mem_rvalid), .MEM_RREADY(mem_rready),
        .rd_protocol_err(err)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear();
        arvalid = '0; araddr = '0; arlen = '0; arburst = '0; rready = '0;
        mem_arready = 0; mem_rdata = '0; mem_rresp = '0; mem_rlast = 0; mem_rvalid = 0;
    endtask

    task automatic do_reset();
        rstn = 0;
        tick();
        rstn = 1;
        clear();
        last_g = 1;
    endtask

    task automatic test_reset();
        clear();
        rstn = 0;
        arvalid = 2'b11; rready = 2'b11; mem_rvalid = 1;
        tick();
        #1;
        if (arready !== 2'b00) begin n_fail++; $display("FAIL reset_arready: got %b want 00", arready); end
        n_chk++;
        if ({mem_arvalid, mem_rready, rvalid} !== 4'b0000) begin n_fail++; $display("FAIL reset_valids: got %b want 0000", {mem_arvalid, mem_rready, rvalid}); end
        n_chk++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_chk++;
        if ({mem_araddr, mem_arlen, mem_arburst} !== '0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", {mem_araddr, mem_arlen, mem_arburst}); end
        n_chk++;
        rstn = 1;
        clear();
        last_g = 1;
        tick();
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        arvalid[0] = 1; araddr[0] = 32'h8000_0000; arlen[0] = 8'd3; arburst[0] = AXI_BURST_INCR;
        #1;
        if (arready !== 2'b01) begin n_fail++; $display("FAIL single_arready: got %b want 01", arready); end
        n_chk++;
        tick();
        last_g = 0;
        arvalid = '0; araddr[0] = '0; arlen[0] = '0;
        #1;
        if ({mem_arvalid, mem_araddr, mem_arlen, mem_arburst} !== {1'b1, 32'h8000_0000, 8'd3, AXI_BURST_INCR}) begin
            n_fail++; $display("FAIL single_ar: got %h want %h", {mem_arvalid, mem_araddr, mem_arlen, mem_arburst}, {1'b1, 32'h8000_0000, 8'd3, AXI_BURST_INCR});
        end
        n_chk++;
        if (arready !== 2'b00) begin n_fail++; $display("FAIL single_arready_addr: got %b want 00", arready); end
        n_chk++;
        mem_arready = 1;
        tick();
        mem_arready = 0;
        rready[0] = 1;
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            mem_rdata = d; mem_rresp = 2'(i); mem_rlast = (i == 3); mem_rvalid = 1;
            #1;
            if ({rvalid, mem_rready, rresp[0], rlast[1]} !== {2'b01, 1'b1, 2'(i), i == 3}) begin
                n_fail++; $display("FAIL single_beat%0d: got %b want %b", i, {rvalid, mem_rready, rresp[0], rlast[1]}, {2'b01, 1'b1, 2'(i), i == 3});
            end
            n_chk++;
            if (rdata[0] !== d || rdata[1] !== d) begin n_fail++; $display("FAIL single_data%0d: got %h/%h want %h", i, rdata[0], rdata[1], d); end
            n_chk++;
            tick();
        end
        clear();
        #1;
        arvalid[1] = 1;
        #1;
        if ({arready, mem_arvalid, rvalid} !== 5'b10000) begin n_fail++; $display("FAIL single_idle_after: got %b want 10000", {arready, mem_arvalid, rvalid}); end
        n_chk++;
        arvalid = '0;
        tick();
    endtask

    task automatic test_rr();
        int g;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            arvalid = 2'b11;
            araddr[0] = 32'h1000 + k; araddr[1] = 32'h2000 + k; arlen = '0;
            g = last_g ^ 1;
            #1;
            if (arready !== 2'(1 << g)) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, arready, 2'(1 << g)); end
            n_chk++;
            tick();
            last_g = g;
            #1;
            if (mem_araddr !== araddr[g]) begin n_fail++; $display("FAIL rr_addr%0d: got %h want %h", k, mem_araddr, araddr[g]); end
            n_chk++;
            mem_arready = 1;
            tick();
            mem_arready = 0; rready = 2'b11; mem_rvalid = 1; mem_rlast = 1; mem_rdata = 64'(k);
            #1;
            if (rvalid !== 2'(1 << g)) begin n_fail++; $display("FAIL rr_rvalid%0d: got %b want %b", k, rvalid, 2'(1 << g)); end
            n_chk++;
            tick();
            mem_rvalid = 0; mem_rlast = 0; rready = '0;
        end
        clear();
        tick();
    endtask

    task automatic test_stall();
        logic [AW-1:0] a;
        a = $urandom;
        arvalid[1] = 1; araddr[1] = a; arlen[1] = 8'd1; arburst[1] = AXI_BURST_WRAP;
        #1;
        if (arready !== 2'b10) begin n_fail++; $display("FAIL stall_grant: got %b want 10", arready); end
        n_chk++;
        tick();
        last_g = 1;
        arvalid = '0; araddr[1] = ~a; arlen[1] = 8'd7; mem_rvalid = 1; rready = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            if ({mem_arvalid, mem_araddr, mem_arlen, mem_arburst} !== {1'b1, a, 8'd1, AXI_BURST_WRAP}) begin
                n_fail++; $display("FAIL stall_ar%0d: got %h want %h", c, {mem_arvalid, mem_araddr, mem_arlen, mem_arburst}, {1'b1, a, 8'd1, AXI_BURST_WRAP});
            end
            n_chk++;
            if ({rvalid, mem_rready} !== 3'b000) begin n_fail++; $display("FAIL stall_r%0d: got %b want 000", c, {rvalid, mem_rready}); end
            n_chk++;
            tick();
        end
        mem_arready = 1;
        mem_rvalid = 0;
        tick();
        mem_arready = 0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1; mem_rlast = (i == 1);
            #1;
            if (rvalid !== 2'b10) begin n_fail++; $display("FAIL stall_beat%0d: got %b want 10", i, rvalid); end
            n_chk++;
            tick();
        end
        clear();
        tick();
    endtask

    task automatic test_rready_toggle();
        logic [DW-1:0] d [2];
        int b;
        d[0] = {$urandom, $urandom}; d[1] = {$urandom, $urandom};
        arvalid[0] = 1; arlen[0] = 8'd1;
        #1;
        if (arready !== 2'b01) begin n_fail++; $display("FAIL toggle_grant: got %b want 01", arready); end
        n_chk++;
        tick();
        last_g = 0;
        arvalid = '0; mem_arready = 1;
        tick();
        mem_arready = 0;
        b = 0;
        for (int c = 0; c < 4 && b < 2; c++) begin
            rready[0] = (c % 2 == 0); mem_rvalid = 1; mem_rdata = d[b]; mem_rlast = (b == 1);
            #1;
            if ({mem_rready, rvalid} !== {rready[0], 2'b01}) begin n_fail++; $display("FAIL toggle_mirror%0d: got %b want %b", c, {mem_rready, rvalid}, {rready[0], 2'b01}); end
            n_chk++;
            if (rdata[0] !== d[b]) begin n_fail++; $display("FAIL toggle_data%0d: got %h want %h", c, rdata[0], d[b]); end
            n_chk++;
            if (rready[0]) b++;
            tick();
        end
        clear();
        #1;
        arvalid[0] = 1;
        #1;
        if ({arready, err} !== 3'b010) begin n_fail++; $display("FAIL toggle_done: got %b want 010", {arready, err}); end
        n_chk++;
        arvalid = '0;
        tick();
    endtask

    task automatic test_protocol_err();
        arvalid[0] = 1; arlen[0] = 8'd3;
        tick();
        last_g = 0;
        arvalid = '0; mem_arready = 1;
        tick();
        mem_arready = 0; rready[0] = 1; mem_rvalid = 1; mem_rlast = 0;
        tick();
        #1;
        if (err !== 1'b0) begin n_fail++; $display("FAIL perr_early: got %b want 0", err); end
        n_chk++;
        mem_rlast = 1;
        tick();
        clear();
        #1;
        if ({err, mem_arvalid, mem_rready} !== 3'b100) begin n_fail++; $display("FAIL perr_set: got %b want 100", {err, mem_arvalid, mem_rready}); end
        n_chk++;
        arvalid[1] = 1; araddr[1] = 32'hCAFE_0040; arlen[1] = 8'd0;
        #1;
        if (arready !== 2'b10) begin n_fail++; $display("FAIL perr_next_grant: got %b want 10", arready); end
        n_chk++;
        tick();
        last_g = 1;
        arvalid = '0;
        #1;
        if ({mem_arvalid, mem_araddr} !== {1'b1, 32'hCAFE_0040}) begin n_fail++; $display("FAIL perr_next_ar: got %h want %h", {mem_arvalid, mem_araddr}, {1'b1, 32'hCAFE_0040}); end
        n_chk++;
        mem_arready = 1;
        tick();
        mem_arready = 0; rready[1] = 1; mem_rvalid = 1; mem_rlast = 1;
        tick();
        clear();
        #1;
        if (err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b want 1", err); end
        n_chk++;
    endtask

    task automatic test_reset_mid();
        arvalid[0] = 1; arlen[0] = 8'd3;
        tick();
        last_g = 0;
        arvalid = '0; mem_arready = 1;
        tick();
        mem_arready = 0; rready = 2'b11; mem_rvalid = 1;
        tick();
        rstn = 0;
        tick();
        rstn = 1;
        last_g = 1;
        #1;
        if ({arready, rvalid, mem_arvalid, mem_rready, err} !== 7'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %b want 0000000", {arready, rvalid, mem_arvalid, mem_rready, err});
        end
        n_chk++;
        clear();
        arvalid = 2'b11;
        #1;
        if (arready !== 2'b01) begin n_fail++; $display("FAIL rstmid_grant: got %b want 01", arready); end
        n_chk++;
        arvalid = '0;
        tick();
    endtask

    task automatic test_overrun();
        arvalid[1] = 1; arlen[1] = 8'd0;
        tick();
        last_g = 1;
        arvalid = '0; mem_arready = 1;
        tick();
        mem_arready = 0; rready[1] = 1; mem_rvalid = 1; mem_rlast = 0;
        tick();
        #1;
        if (err !== 1'b1) begin n_fail++; $display("FAIL overrun_err: got %b want 1", err); end
        n_chk++;
        mem_rlast = 1;
        tick();
        clear();
        #1;
        if ({mem_rready, mem_arvalid, rvalid} !== 4'b0) begin n_fail++; $display("FAIL overrun_exit: got %b want 0000", {mem_rready, mem_arvalid, rvalid}); end
        n_chk++;
        do_reset();
        tick();
    endtask

    task automatic test_random();
        logic [1:0] req;
        int g, r, b, c, w;
        logic [AW-1:0] ea;
        logic [7:0] el;
        logic [1:0] eb;
        logic [1:0] erv;
        for (int it = 0; it < 40; it++) begin
            req = 2'($urandom_range(1, 3));
            for (int m = 0; m < 2; m++) begin
                araddr[m] = $urandom;
                arlen[m] = 8'($urandom_range(0, 3));
                r = $urandom_range(0, 2);
                arburst[m] = (r == 0) ? AXI_BURST_FIXED : (r == 1) ? AXI_BURST_INCR : AXI_BURST_WRAP;
            end
            arvalid = req;
            g = (req == 2'b11) ? (last_g ^ 1) : (req == 2'b01) ? 0 : 1;
            ea = araddr[g]; el = arlen[g]; eb = arburst[g];
            #1;
            if (arready !== 2'(1 << g)) begin n_fail++; $display("FAIL rand_grant%0d: got %b want %b", it, arready, 2'(1 << g)); end
            n_chk++;
            tick();
            last_g = g;
            arvalid = 2'($urandom); araddr[0] = $urandom; araddr[1] = $urandom; arlen[0] = 8'($urandom); arlen[1] = 8'($urandom);
            w = $urandom_range(0, 3);
            for (int k = 0; k <= w; k++) begin
                mem_arready = (k == w);
                #1;
                if ({mem_arvalid, mem_araddr, mem_arlen, mem_arburst, arready} !== {1'b1, ea, el, eb, 2'b00}) begin
                    n_fail++; $display("FAIL rand_ar%0d: got %h want %h", it, {mem_arvalid, mem_araddr, mem_arlen, mem_arburst, arready}, {1'b1, ea, el, eb, 2'b00});
                end
                n_chk++;
                tick();
            end
            mem_arready = 0;
            b = 0;
            c = 0;
            while (b <= int'(el) && c < 100) begin
                mem_rvalid = ($urandom_range(0, 3) != 0);
                rready = 2'($urandom);
                mem_rdata = {$urandom, $urandom};
                mem_rlast = (b == int'(el));
                erv = mem_rvalid ? 2'(1 << g) : 2'b00;
                #1;
                if ({rvalid, mem_rready} !== {erv, rready[g]}) begin n_fail++; $display("FAIL rand_r%0d_%0d: got %b want %b", it, c, {rvalid, mem_rready}, {erv, rready[g]}); end
                n_chk++;
                if (mem_rvalid && rdata[g] !== mem_rdata) begin n_fail++; $display("FAIL rand_data%0d_%0d: got %h want %h", it, c, rdata[g], mem_rdata); end
                n_chk++;
                if (mem_rvalid && rready[g]) b++;
                tick();
                c++;
            end
            if (c >= 100) begin n_fail++; $display("FAIL rand_timeout%0d: got %0d beats want %0d", it, b, int'(el) + 1); end
            n_chk++;
            clear();
        end
        #1;
        if ({err, mem_arvalid, mem_rready} !== 3'b000) begin n_fail++; $display("FAIL rand_end: got %b want 000", {err, mem_arvalid, mem_rready}); end
        n_chk++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end

    initial begin
        clear();
        rstn = 0;
        test_reset();
        test_single();
        test_rr();
        test_stall();
        test_rready_toggle();
        test_protocol_err();
        test_reset_mid();
        test_overrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
